// File: rtl/branch_defs.sv
// Shared encodings for branch compare codes, decoded branch types and the
// redirect FSM, used by branch_judge and branch_resolve.
package branch_defs;

   typedef enum logic [1:0] {
      BRANCH_DEFAULT = 2'b00,
      BRANCH_EQUAL   = 2'b01,
      BRANCH_LT      = 2'b10,
      BRANCH_GT      = 2'b11
   } cmp_code_t;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_BEQ  = 3'b001,
      BR_BNE  = 3'b010,
      BR_BLEZ = 3'b011,
      BR_BGTZ = 3'b100,
      BR_BLTZ = 3'b101,
      BR_BGEZ = 3'b110,
      BR_JUMP = 3'b111
   } br_type_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } resolve_state_t;

endpackage

// File: rtl/branch_taken_decode.sv
// Combinational taken/not-taken decision from decoded branch type and the
// compare code produced by branch_judge.
module branch_taken_decode
   import branch_defs::*;
(
   input  logic [2:0] br_type,
   input  logic [1:0] cmp_result,
   output logic       taken
);

   cmp_code_t cmp;
   br_type_t  typ;

   assign cmp = cmp_code_t'(cmp_result);
   assign typ = br_type_t'(br_type);

   // BRANCH_DEFAULT matches none of the conditional terms, so it is never taken
   always_comb begin
      taken = 1'b0;
      case (typ)
         BR_BEQ:  taken = (cmp == BRANCH_EQUAL);
         BR_BNE:  taken = (cmp == BRANCH_LT) || (cmp == BRANCH_GT);
         BR_BLEZ: taken = (cmp == BRANCH_EQUAL) || (cmp == BRANCH_LT);
         BR_BGTZ: taken = (cmp == BRANCH_GT);
         BR_BLTZ: taken = (cmp == BRANCH_LT);
         BR_BGEZ: taken = (cmp == BRANCH_EQUAL) || (cmp == BRANCH_GT);
         BR_JUMP: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolution: taken decision, target computation, redirect
// request to fetch under valid/ready, IF/ID flush and branch counters.
module branch_resolve
   import branch_defs::*;
#(
   parameter int PC_WIDTH  = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic                 id_stall,
   input  logic [2:0]           br_type,
   input  logic [1:0]           cmp_result,
   input  logic [PC_WIDTH-1:0]  id_pc,
   input  logic [15:0]          imm16,
   input  logic [PC_WIDTH-1:0]  jump_target,
   output logic                 redir_valid,
   output logic [PC_WIDTH-1:0]  redir_pc,
   input  logic                 redir_ready,
   output logic                 flush_ifid,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] branch_cnt,
   output logic [CNT_WIDTH-1:0] taken_cnt
);

   resolve_state_t              state, state_nxt;
   logic                        taken;
   logic                        resolve;
   logic                        take_redirect;
   logic signed [PC_WIDTH-1:0]  br_offset;
   logic [PC_WIDTH-1:0]         cond_target;
   logic [PC_WIDTH-1:0]         target;

   branch_taken_decode u_taken_decode (
      .br_type    (br_type),
      .cmp_result (cmp_result),
      .taken      (taken)
   );

   // Word offset: sign-extended imm16 shifted left by 2; sums wrap modulo 2^PC_WIDTH
   assign br_offset   = signed'({{(PC_WIDTH-18){imm16[15]}}, imm16, 2'b00});
   assign cond_target = id_pc + PC_WIDTH'(4) + $unsigned(br_offset);
   assign target      = (br_type_t'(br_type) == BR_JUMP) ? jump_target : cond_target;

   assign resolve       = id_valid && !id_stall &&
                          (br_type_t'(br_type) != BR_NONE) && (state == ST_IDLE);
   assign take_redirect = resolve && taken;

   assign redir_valid = (state == ST_PEND);
   assign busy        = (state == ST_PEND);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (take_redirect) state_nxt = ST_PEND;
         ST_PEND: if (redir_ready)   state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         flush_ifid <= 1'b0;
         redir_pc   <= '0;
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         flush_ifid <= take_redirect;
         if (resolve)
            branch_cnt <= branch_cnt + CNT_WIDTH'(1);
         // redir_pc only loads on entry to PEND, so it is stable for the whole request
         if (take_redirect) begin
            taken_cnt <= taken_cnt + CNT_WIDTH'(1);
            redir_pc  <= target;
         end
      end
   end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution and PC-redirect stage, sitting directly downstream of `branch_judge` in the ID stage of the pipelined MIPS core. It turns the 2-bit compare code and the decoded branch type into a taken/not-taken decision and computes the branch target. On a taken branch it holds a redirect request to the fetch unit under a valid/ready handshake, flushes IF/ID, and stalls ID until fetch accepts. It also maintains branch/taken performance counters.

## Interface
Parameters:
- `PC_WIDTH`, 32, program-counter width
- `CNT_WIDTH`, 32, performance-counter width

Ports (single clock `clk`; `rst` is synchronous and active-high):
- `clk`  in  1  core clock
- `rst`  in  1  synchronous active-high reset
- `id_valid`  in  1  ID holds a valid instruction
- `id_stall`  in  1  ID held by hazard unit; no resolution this cycle
- `br_type`  in  3  decoded branch type (package encoding)
- `cmp_result`  in  2  compare code from `branch_judge`
- `id_pc`  in  PC_WIDTH  PC of the ID instruction
- `imm16`  in  16  branch offset field
- `jump_target`  in  PC_WIDTH  precomputed target for `BR_JUMP`
- `redir_valid`  out  1  redirect request to fetch
- `redir_pc`  out  PC_WIDTH  redirect target
- `redir_ready`  in  1  fetch accepts redirect
- `flush_ifid`  out  1  one-cycle IF/ID flush pulse
- `busy`  out  1  redirect pending; ID must stall
- `branch_cnt`  out  CNT_WIDTH  resolved branches
- `taken_cnt`  out  CNT_WIDTH  taken branches

## Operation
- Compare codes: `BRANCH_DEFAULT`=00, `BRANCH_EQUAL`=01, `BRANCH_LT`=10, `BRANCH_GT`=11.
- Branch types: `BR_NONE`=000, `BR_BEQ`=001, `BR_BNE`=010, `BR_BLEZ`=011, `BR_BGTZ`=100, `BR_BLTZ`=101, `BR_BGEZ`=110, `BR_JUMP`=111.
- Taken rules: BEQ←EQUAL; BNE←LT|GT; BLEZ←EQUAL|LT; BGTZ←GT; BLTZ←LT; BGEZ←EQUAL|GT; JUMP always taken; NONE never taken. A `BRANCH_DEFAULT` compare code means not taken for every conditional type.
- Target: conditional types use `id_pc + 4 + (sext(imm16) << 2)`, modulo 2^PC_WIDTH (wraps silently). JUMP uses `jump_target`.
- A resolve event occurs when `id_valid & ~id_stall & br_type!=BR_NONE & state==IDLE`.
- FSM, two states:
  - IDLE: on a resolve event, `branch_cnt` increments. If taken: latch `redir_pc`, increment `taken_cnt`, go to PEND. If not taken: stay in IDLE.
  - PEND: hold `redir_valid`=1 and `redir_pc` stable. Go to IDLE at the edge where `redir_ready`=1. All ID inputs are ignored in PEND.
- `busy` = (state==PEND), combinational from state.
- Both counters wrap from all-ones to 0.

## Timing
- Reset: state IDLE; `redir_valid`=0, `redir_pc`=0, `flush_ifid`=0, `busy`=0, both counters 0. `rst` asserted while in PEND drops the request on the next edge with no handshake.
- A taken resolve at edge N gives `redir_valid`=1, `busy`=1 and `flush_ifid`=1 from cycle N+1. `flush_ifid` lasts exactly one cycle.
- Counters update at the resolve edge and are visible in cycle N+1.
- Handshake: once asserted, `redir_valid` stays high and `redir_pc` stays constant until the handshake edge (`valid & ready`). `redir_valid` is 0 in the following cycle. Minimum PEND residency is 1 cycle.
- `redir_ready` while `redir_valid`=0 has no effect.
- No new resolve can occur in the cycle after acceptance unless state is IDLE at that edge. A branch can therefore be resolved at earliest the cycle after `redir_valid` falls.
- `id_stall`=1 suppresses resolution and counting even when `id_valid`=1.

## Structure
- Shared package/header `branch_defs` holds the `BRANCH_*` compare codes, the `BR_*` type encodings and the state encodings. `branch_judge` uses the same header.
- One sub-module: `branch_taken_decode`, purely combinational (`br_type`, `cmp_result` → `taken`). The FSM, target adder and counters stay in `branch_resolve`.

## Test plan
- Reset, then hold: all outputs 0 for 5 cycles with `id_valid`=0.
- BEQ, `cmp_result`=01, `id_pc`=0x0040_0000, `imm16`=0x0003, `redir_ready`=1: next cycle `redir_valid`=1, `redir_pc`=0x0040_0010, `flush_ifid`=1. Then `redir_valid`=0, `branch_cnt`=1, `taken_cnt`=1.
- BNE, `cmp_result`=01: not taken, no redirect, `branch_cnt`+1, `taken_cnt` unchanged. Separately, BGEZ with `cmp_result`=00 is not taken.
- Negative offset: BLTZ, `cmp_result`=10, `id_pc`=0x0000_0000, `imm16`=0xFFFE → `redir_pc`=0xFFFF_FFFC (wrap).
- JUMP to 0x1234_5678 with `redir_ready`=0 for 4 cycles: `redir_valid`/`busy` held 4 cycles with the target stable, and a BEQ presented meanwhile is ignored. Raise ready → accepted, IDLE next cycle.
- Assert `rst` during PEND: next cycle all outputs 0; `id_stall`=1 with a valid BEQ produces no count and no redirect.
